// File: rtl/uart_tx_arbiter.sv
// Two-requester UART transmitter: round-robin grant, then one asynchronous
// frame (start, 8 data LSB-first, optional parity, 1-2 stop bits) per grant.
module uart_tx_arbiter #(
  parameter int CLKS_PER_BIT = 16,
  parameter int PARITY_EN    = 0,
  parameter int PARITY_ODD   = 0,
  parameter int STOP_BITS    = 1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       req0_valid,
  input  logic [7:0] req0_data,
  output logic       req0_ready,
  input  logic       req1_valid,
  input  logic [7:0] req1_data,
  output logic       req1_ready,
  output logic       tx,
  output logic       busy,
  output logic       grant_id,
  output logic       frame_done
);

  localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP
  } state_t;

  state_t          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [2:0]      bit_q, bit_d;
  logic [7:0]      shift_q, shift_d;
  logic            par_q, par_d;
  logic            tx_q, tx_d;
  logic            done_q, done_d;
  logic            grant_q, grant_d;
  logic            last_q, last_d;

  logic            winner;
  logic            idle;
  logic            hs;
  logic            tc;
  logic [7:0]      sel_data;

  // Round-robin winner and handshake qualification.
  always_comb begin
    if (req0_valid && req1_valid) winner = ~last_q;
    else                          winner = req1_valid;
    idle       = (state_q == IDLE);
    req0_ready = idle & ~reset & req0_valid & ~winner;
    req1_ready = idle & ~reset & req1_valid & winner;
    hs         = req0_ready | req1_ready;
    sel_data   = winner ? req1_data : req0_data;
    tc         = (cnt_q == CW'(CLKS_PER_BIT - 1));
  end

  // Next-state logic; tx_d is the line level for the cycle after the edge,
  // so each transition also loads the level of the bit being entered.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    bit_d   = bit_q;
    shift_d = shift_q;
    par_d   = par_q;
    tx_d    = tx_q;
    done_d  = 1'b0;
    grant_d = grant_q;
    last_d  = last_q;

    if (state_q == IDLE) begin
      tx_d  = 1'b1;
      cnt_d = '0;
      bit_d = '0;
      if (hs) begin
        shift_d = sel_data;
        par_d   = (^sel_data) ^ (PARITY_ODD != 0);
        grant_d = winner;
        last_d  = winner;
        state_d = START;
        tx_d    = 1'b0;
      end
    end else begin
      cnt_d = tc ? '0 : cnt_q + CW'(1);
      case (state_q)
        START: begin
          if (tc) begin
            state_d = DATA;
            tx_d    = shift_q[0];
          end
        end
        DATA: begin
          if (tc) begin
            shift_d = shift_q >> 1;
            bit_d   = bit_q + 3'd1;
            if (bit_q == 3'd7) begin
              if (PARITY_EN != 0) begin
                state_d = PARITY;
                tx_d    = par_q;
              end else begin
                state_d = STOP;
                tx_d    = 1'b1;
              end
            end else begin
              tx_d = shift_q[1];
            end
          end
        end
        PARITY: begin
          if (tc) begin
            state_d = STOP;
            tx_d    = 1'b1;
          end
        end
        STOP: begin
          if (tc) begin
            if (bit_q == 3'(STOP_BITS - 1)) begin
              state_d = IDLE;
              done_d  = 1'b1;
              bit_d   = '0;
            end else begin
              bit_d = bit_q + 3'd1;
            end
            tx_d = 1'b1;
          end
        end
        default: begin
          state_d = IDLE;
          tx_d    = 1'b1;
        end
      endcase
    end
  end

  // State and datapath registers; reset forces the line idle immediately.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      bit_q   <= '0;
      shift_q <= '0;
      par_q   <= 1'b0;
      tx_q    <= 1'b1;
      done_q  <= 1'b0;
      grant_q <= 1'b0;
      last_q  <= 1'b1;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      bit_q   <= bit_d;
      shift_q <= shift_d;
      par_q   <= par_d;
      tx_q    <= tx_d;
      done_q  <= done_d;
      grant_q <= grant_d;
      last_q  <= last_d;
    end
  end

  assign tx         = tx_q;
  assign busy       = (state_q != IDLE);
  assign grant_id   = grant_q;
  assign frame_done = done_q;

endmodule

// File: doc/uart_tx_arbiter.md
# uart_tx_arbiter

Shares one UART serial transmit line between two byte-stream requesters. Arbitrates round-robin, serializes the granted byte into a standard asynchronous frame (start, LSB-first data, optional parity, 1 or 2 stop bits) and paces it with an internal baud counter. Sits between the transmit-side sequence drivers and the `tx` wire of the UART interface, and is the only driver of that wire.

## Interface
- `CLKS_PER_BIT`, 16, clock cycles per serial bit; must be ≥ 2.
- `PARITY_EN`, 0, 1 inserts a parity bit after the data bits.
- `PARITY_ODD`, 0, 0 selects even parity, 1 selects odd; ignored when `PARITY_EN`=0.
- `STOP_BITS`, 1, number of stop bits; legal values are 1 and 2.

Ports:
- `clk`  in  1  clock; all logic on the rising edge.
- `reset`  in  1  asynchronous, active-high reset.
- `req0_valid`  in  1  requester 0 has a byte.
- `req0_data`  in  8  requester 0 byte.
- `req0_ready`  out  1  requester 0 byte accepted this cycle.
- `req1_valid`  in  1  requester 1 has a byte.
- `req1_data`  in  8  requester 1 byte.
- `req1_ready`  out  1  requester 1 byte accepted this cycle.
- `tx`  out  1  serial line; idles high.
- `busy`  out  1  frame in progress (state ≠ IDLE).
- `grant_id`  out  1  requester owning the current or last frame.
- `frame_done`  out  1  one-cycle pulse when a frame completes.

## Operation
- FSM states: IDLE → START → DATA → PARITY (only if `PARITY_EN`) → STOP → IDLE.
- IDLE: `tx`=1. Grant is computed combinationally:
  - Only one `reqK_valid` high: that K wins.
  - Both high: the winner is the requester other than `last_grant`.
  - `reqK_ready` = (state==IDLE) & (winner==K). Handshake is `valid & ready`.
- On handshake:
  - Capture the byte into the shift register.
  - Set `last_grant` and `grant_id` to K; go to START.
- START drives `tx`=0. DATA drives `shift[0]`, shifting right once per bit for 8 bits. PARITY drives ^data (even) or ~^data (odd). STOP drives `tx`=1 for `STOP_BITS` bits.
- A baud counter counts 0..`CLKS_PER_BIT`-1 in every non-IDLE state. Bit and state advance on terminal count. A 3-bit bit index covers DATA.
- Requesters must hold valid and data stable until ready. Deasserting valid before the handshake has no effect.
- Only `tx` is registered toward the line. `ready` is combinational from state and valids.

## Timing
- Reset values: `tx`=1, `busy`=0, `grant_id`=0, `frame_done`=0, `reqK_ready`=0 while reset is asserted, `last_grant`=1 (so req0 wins the first tie), state=IDLE, counters=0.
- Let H be the handshake cycle and C = `CLKS_PER_BIT`. N = 1+8+`PARITY_EN`+`STOP_BITS`.
- `tx`=0 during cycles H+1..H+C.
- Data bit i occupies cycles H+1+(i+1)·C .. H+(i+2)·C.
- The last stop bit ends at cycle H+N·C.
- Cycle H+N·C+1: state=IDLE, `frame_done`=1, `busy`=0. A new handshake is allowed in this same cycle.
- Minimum handshake-to-handshake spacing is N·C+1 cycles (161 for the defaults).
- `busy`=1 from H+1 through H+N·C.
- Reset asserted mid-frame:
  - `tx` goes to 1 immediately (asynchronously) and state goes to IDLE.
  - The partial frame is dropped, `frame_done` is not pulsed, and `last_grant` returns to 1.
- `grant_id` holds its value between frames.

## Test plan
- Defaults, req0 sends 0xA5 at H=0:
  - `tx` low for cycles 1–16.
  - Data bits 1,0,1,0,0,1,0,1 in 16-cycle slots from cycle 17.
  - Stop high for cycles 145–160.
  - `frame_done`=1 at cycle 161, `grant_id`=0.
- Both valid from reset with 0x11/0x22 held continuously:
  - Grants go req0, req1, req0, req1.
  - Handshakes occur at cycles 0, 161, 322, 483.
- Only req1 valid continuously:
  - req1 wins every frame.
  - Handshakes are exactly 161 cycles apart.
  - `tx` is high for exactly 16 cycles between frames, plus the single IDLE cycle.
- `PARITY_EN`=1, `PARITY_ODD`=0, byte 0x07:
  - Parity bit is 1, occupying cycles 145–160.
  - Stop occupies cycles 161–176; `frame_done` is at 177.
  - Repeat with `PARITY_ODD`=1: parity bit is 0.
- `STOP_BITS`=2, `CLKS_PER_BIT`=4, byte 0x00: `tx` low for cycles 1–36, high for cycles 37–44, `frame_done` at 45.
- Reset pulsed at cycle 70 of a req0 frame:
  - `tx`=1 and `busy`=0 at once, with no `frame_done`.
  - After release, with both valid, req0 is granted first.
